instr_prefetch_queue: RTL
=========================

# instr_prefetch_queue

Instruction fetch stage that sits directly upstream of the `top` core datapath.
- Drives the instruction-memory port (`IM_*`) and keeps a small FIFO of fetched 32-bit words, each tagged with its PC.
- Presents the oldest word to the core's `instruction` input with a valid/ready handshake.
- On a branch or jump `redirect` it flushes all queued and in-flight words and restarts fetch at the new PC.

## Interface
Parameters:
- DataSize, 32, instruction word width
- MemSize, 10, PC / IM address width
- Depth, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- IM_enable  out  1  IM chip enable; equals IM_read
- IM_read  out  1  IM read strobe; data returns on IM_out one cycle later
- IM_write  out  1  constant 0
- IM_address  out  MemSize  fetch address
- IM_out  in  DataSize  IM read data, valid in the cycle after IM_read
- instruction  out  DataSize  FIFO head word
- instr_pc  out  MemSize  PC of the head word
- instr_valid  out  1  head entry valid
- instr_ready  in  1  core accepts the head this cycle
- redirect  in  1  one-cycle pulse: flush and restart
- redirect_pc  in  MemSize  new fetch PC, sampled when redirect=1
- count  out  log2(Depth)+1  FIFO occupancy

## Operation
State machine:
- IDLE: entered on reset; no fetch is issued.
- IDLE -> RUN unconditionally on the first clk edge after reset deasserts.
- RUN -> FLUSH when redirect=1.
- FLUSH -> RUN on the next edge. A redirect arriving while in FLUSH reloads fetch_pc and the state stays FLUSH.

Issue rule (combinational):
- IM_read = (state==RUN) && !redirect && (count + inflight < Depth).
- IM_address = fetch_pc.
- On each issue: fetch_pc <= fetch_pc+1, wrapping 2^MemSize-1 -> 0. inflight <= 1 and the issued PC is stored in the pending tag.
- A cycle with no issue sets inflight <= 0.

Return and push:
- When inflight=1 and the state is not FLUSH and redirect=0, push {IM_out, pending tag} into the FIFO.
- inflight=1 in FLUSH, or in any cycle with redirect=1, discards the returned word.

Pop:
- instr_valid = (count != 0).
- instruction and instr_pc come from the head entry combinationally (show-ahead).
- A pop occurs when instr_valid && instr_ready && !redirect.

Push and pop in the same cycle leave count unchanged and both pointers advance.

Redirect, highest priority:
- count <= 0, pointers <= 0, fetch_pc <= redirect_pc.
- Any pop or push in that cycle is cancelled.

Overflow cannot occur by construction. Push into a full FIFO or pop from an empty one is an assertion failure.

Reset (async, reset=0), all state cleared immediately:
- state=IDLE, fetch_pc=0, count=0, inflight=0.
- IM_read=IM_enable=IM_write=0, IM_address=0.
- instr_valid=0, instruction=0, instr_pc=0 (entries cleared).

## Timing
- Fetch latency: IM_read=1 in cycle N; the word is pushed at the edge ending N+1; instr_valid=1 from cycle N+2.
- First fetch after reset release at edge E0: IDLE during E0–E1, IM_read for PC 0 in the cycle after E1, instr_valid two cycles later.
- Throughput: one instruction per cycle while instr_ready=1 and no redirect.
- Redirect pulse in cycle R:
  - cycle R+1 is FLUSH with no issue;
  - redirect_pc is issued in R+2;
  - the first new instr_valid appears in R+4.
- Backpressure: with instr_ready=0, issue stops once count+inflight=Depth; resumes the cycle after a pop frees a slot.
- count updates only on clk edges; no combinational path from instr_ready to IM_read.

## Test plan
- Reset values: hold reset=0 mid-stream with count=3 -> all outputs go to 0 immediately, without waiting for clk. Release -> IM_address 0 issued two edges later.
- Streaming: IM returns word = 0xA000_0000+address, instr_ready=1 -> instr_pc 0,1,2,… on consecutive cycles with matching instruction. Steady state is one per cycle.
- Backpressure: instr_ready=0 -> exactly 4 reads (addresses 0–3), count=4, IM_read=0. One pop -> address 4 issued the following cycle.
- Redirect: after instr_pc 5 is presented, pulse redirect with redirect_pc=0x200 -> count=0 next cycle and the in-flight word is discarded. The next valid instr_pc is 0x200, then 0x201.
- Wrap: redirect_pc=0x3FE, streaming -> instr_pc sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Simultaneous events: redirect coincident with push and pop at count=2 -> count=0 next cycle, no stale word ever valid. IM_write stays 0 throughout.

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// Prefetch stage: issues IM reads ahead of the core and buffers PC-tagged words in a small FIFO.
// A redirect flushes queued and in-flight words, then fetch restarts at redirect_pc.
module instr_prefetch_queue #(
  parameter int DataSize = 32,
  parameter int MemSize  = 10,
  parameter int Depth    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    IM_enable,
  output logic                    IM_read,
  output logic                    IM_write,
  output logic [MemSize-1:0]      IM_address,
  input  logic [DataSize-1:0]     IM_out,
  output logic [DataSize-1:0]     instruction,
  output logic [MemSize-1:0]      instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    redirect,
  input  logic [MemSize-1:0]      redirect_pc,
  output logic [$clog2(Depth):0]  count
);

  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [CW-1:0] LP_FULL    = CW'(Depth);
  localparam logic [OW-1:0] LP_OCC_LIM = OW'(Depth);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              r_state;
  logic [MemSize-1:0]  r_fetch_pc;
  logic [MemSize-1:0]  r_pend_pc;
  logic                r_inflight;
  logic [CW-1:0]       r_count;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [DataSize-1:0] r_mem_dat [Depth];
  logic [MemSize-1:0]  r_mem_pc  [Depth];

  logic                w_issue;
  logic                w_push;
  logic                w_pop;
  logic                w_valid;
  logic [OW-1:0]       w_occ;

  // Occupancy includes the word still in flight so a full FIFO can never be overrun.
  assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_valid = (r_count != '0);
  assign w_issue = (r_state == ST_RUN) && !redirect && (w_occ < LP_OCC_LIM);
  assign w_push  = r_inflight && (r_state != ST_FLUSH) && !redirect;
  assign w_pop   = w_valid && instr_ready && !redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= ST_RUN;
        ST_RUN:   if (redirect) r_state <= ST_FLUSH;
        ST_FLUSH: if (!redirect) r_state <= ST_RUN;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= '0;
      r_pend_pc  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + MemSize'(1);
        r_pend_pc  <= r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem_dat[i] <= '0;
        r_mem_pc[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_dat[r_wr_ptr] <= IM_out;
      r_mem_pc[r_wr_ptr]  <= r_pend_pc;
    end
  end

  assign IM_read     = w_issue;
  assign IM_enable   = w_issue;
  assign IM_write    = 1'b0;
  assign IM_address  = r_fetch_pc;
  assign instruction = r_mem_dat[r_rd_ptr];
  assign instr_pc    = r_mem_pc[r_rd_ptr];
  assign instr_valid = w_valid;
  assign count       = r_count;

  always @(posedge clk) begin
    if (reset) begin
      assert (!(w_push && !w_pop && (r_count == LP_FULL)));
      assert (!(w_pop && (r_count == '0)));
    end
  end

endmodule
